// File: rtl/alu_dec_pkg.sv
// ---------------------------------------------------------------------------
// alu_dec_pkg
// Shared constants and types for the ALU issue decoder.
//   - RV32I opcode constants for OP, OP-IMM and LUI
//   - funct3 codes F3_ADD..F3_AND and funct7 qualifiers F7_BASE / F7_ALT
//   - dec_fields_t: decoded fields handed from rv_alu_decode to the top
//   - issue_state_e: EMPTY/FULL state of the single output register
// The LUI opcode is only decoded when ALU_DEC_LUI_EN is defined.
// ---------------------------------------------------------------------------
package alu_dec_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // Operand selection is carried as flags; the top owns the XLEN-wide data.
  // imm is already in its final 32-bit form (sign-extended I-imm, zero-
  // extended shamt, or U-imm) and is sign-extended to XLEN by the top.
  typedef struct packed {
    logic [2:0]  alu_op;
    logic [6:0]  alu_op_ext;
    logic [4:0]  rd;
    logic        illegal;
    logic        op1_rs1;   // 1: op1 = rs1 value, 0: op1 = 0
    logic        op2_rs2;   // 1: op2 = rs2 value, 0: op2 = imm
    logic [31:0] imm;
  } dec_fields_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } issue_state_e;

endpackage

// File: rtl/rv_alu_decode.sv
// ---------------------------------------------------------------------------
// rv_alu_decode
// Purely combinational decode of an RV32I OP / OP-IMM instruction into the
// fields the ALU needs. Anything not decodable comes out with illegal=1 and
// every other field zero.
// Ports:
//   instr_i   in  32  raw instruction word
//   fields_o  out     decoded fields (dec_fields_t)
// Optional: ALU_DEC_LUI_EN makes LUI legal (issued as ADD 0 + U-imm).
// ---------------------------------------------------------------------------
module rv_alu_decode
  import alu_dec_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_fields_t fields_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_field;
  logic [4:0]  shamt;
  logic [31:0] imm_i;
  logic        legal;
  dec_fields_t dec;

  assign opcode   = instr_i[6:0];
  assign rd_field = instr_i[11:7];
  assign funct3   = instr_i[14:12];
  assign funct7   = instr_i[31:25];
  assign shamt    = instr_i[24:20];
  assign imm_i    = {{20{instr_i[31]}}, instr_i[31:20]};

  // The rs1 index was already consumed by the register-file read.
  logic unused_rs1_idx;
  assign unused_rs1_idx = ^instr_i[19:15];

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.alu_op     = funct3;
        dec.alu_op_ext = funct7;
        dec.op1_rs1    = 1'b1;
        dec.op2_rs2    = 1'b1;
        legal = (funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
      end
      OPC_OP_IMM: begin
        dec.alu_op  = funct3;
        dec.op1_rs1 = 1'b1;
        case (funct3)
          F3_SLL: begin
            dec.imm = {27'd0, shamt};
            legal   = (funct7 == F7_BASE);
          end
          F3_SR: begin
            // imm[11:5] doubles as the SRL/SRA qualifier.
            dec.imm        = {27'd0, shamt};
            dec.alu_op_ext = funct7;
            legal          = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          F3_ADD, F3_SLT, F3_SLTU, F3_XOR, F3_OR, F3_AND: begin
            // Upper imm bits are ordinary immediate bits here, never a SUBI.
            dec.imm = imm_i;
            legal   = 1'b1;
          end
        endcase
      end
`ifdef ALU_DEC_LUI_EN
      OPC_LUI: begin
        // Issued as ADD with a zero first operand.
        dec.imm = {instr_i[31:12], 12'd0};
        legal   = 1'b1;
      end
`endif
      default: begin
        legal = 1'b0;
      end
    endcase

    if (legal) begin
      dec.rd = rd_field;
    end else begin
      // Clear everything so an illegal op can never produce a side effect.
      dec         = '0;
      dec.illegal = 1'b1;
    end
    fields_o = dec;
  end

endmodule

// File: rtl/alu_issue_decoder.sv
// ---------------------------------------------------------------------------
// alu_issue_decoder
// Decode/issue stage in front of the ALU. Accepts one instruction plus its
// rs1/rs2 values per valid/ready handshake, decodes it with rv_alu_decode and
// holds the ALU-facing result in one output register (EMPTY/FULL).
// Ports:
//   clk, rst (sync, active-high)
//   in_valid / in_ready, in_instr, in_rs1_val, in_rs2_val   upstream side
//   out_valid / out_ready, ALU_op, ALU_op_ext, op1, op2,
//   rd, illegal                                             downstream side
//   issue_cnt   number of legal instructions consumed downstream (wraps)
// Optional: ALU_DEC_LUI_EN enables LUI decoding.
// ---------------------------------------------------------------------------
module alu_issue_decoder
  import alu_dec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_rs1_val,
  input  logic [XLEN-1:0]  in_rs2_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       ALU_op,
  output logic [6:0]       ALU_op_ext,
  output logic [XLEN-1:0]  op1,
  output logic [XLEN-1:0]  op2,
  output logic [4:0]       rd,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_cnt
);

  dec_fields_t fields;

  rv_alu_decode u_decode (
    .instr_i  (in_instr),
    .fields_o (fields)
  );

  issue_state_e     state_q, state_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [6:0]       alu_op_ext_q, alu_op_ext_d;
  logic [XLEN-1:0]  op1_q, op1_d;
  logic [XLEN-1:0]  op2_q, op2_d;
  logic [4:0]       rd_q, rd_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;

  logic accept;
  logic consume;

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  // Next-state / next-data logic.
  always_comb begin
    state_d      = state_q;
    alu_op_d     = alu_op_q;
    alu_op_ext_d = alu_op_ext_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    rd_d         = rd_q;
    illegal_d    = illegal_q;
    issue_cnt_d  = issue_cnt_q;

    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL: begin
        if (accept)       state_d = ST_FULL;
        else if (consume) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase

    if (consume && !illegal_q) begin
      issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end

    // Fields only change on accept; a bare consume leaves them as they were.
    if (accept) begin
      alu_op_d     = fields.alu_op;
      alu_op_ext_d = fields.alu_op_ext;
      rd_d         = fields.rd;
      illegal_d    = fields.illegal;
      op1_d        = fields.op1_rs1 ? in_rs1_val : '0;
      op2_d        = fields.op2_rs2 ? in_rs2_val : XLEN'($signed(fields.imm));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      alu_op_q     <= '0;
      alu_op_ext_q <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      rd_q         <= '0;
      illegal_q    <= 1'b0;
      issue_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      alu_op_q     <= alu_op_d;
      alu_op_ext_q <= alu_op_ext_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      rd_q         <= rd_d;
      illegal_q    <= illegal_d;
      issue_cnt_q  <= issue_cnt_d;
    end
  end

  assign ALU_op     = alu_op_q;
  assign ALU_op_ext = alu_op_ext_q;
  assign op1        = op1_q;
  assign op2        = op2_q;
  assign rd         = rd_q;
  assign illegal    = illegal_q;
  assign issue_cnt  = issue_cnt_q;

endmodule
